sdr_bank0_protocol_checker: RTL and testbench
=============================================

// Module: sdr_bank0_protocol_checker
// PURPOSE
//  Synthesizable SDRAM bus monitor that tracks the state of bank 0.
//  It snoops the command pins between the SDRAM controller core and the
//  SDRAM device, and flags every bank-0 command that is illegal in the
//  current bank state. It sits passively on the controller-to-RAM bus and
//  drives no SDRAM pins.
// PARAMETERS
//  BURST_LENGTH  1  cycles a RD/WR (optionally with auto-precharge) remains in burst
//  TRCD          1  ACTIVATING dwell threshold (exit when dwell count >= TRCD)
//  TRAS          1  reserved; carried for interface compatibility, unused
//  TCAS          1  reserved; unused
//  TRP           1  reserved; unused
//  FAILW        16  width of the fail counter
// PORTS
//  sdram_clk      in   1      SDRAM clock; all logic on rising edge
//  sdram_rst      in   1      synchronous reset, active-high
//  sdr_init_done  in   1      controller initialization complete
//  sdr_cs_n       in   1      chip select, active-low
//  sdr_ras_n      in   1      RAS, active-low
//  sdr_cas_n      in   1      CAS, active-low
//  sdr_we_n       in   1      write enable, active-low
//  sdr_ba         in   2      bank address
//  sdr_addr10     in   1      sdr_addr[10]: auto-precharge / precharge-all
//  bank_state     out  4      current bank-0 state (bank_state_t encoding)
//  chk_valid      out  1      a check was performed last cycle
//  chk_fail       out  1      the last check failed (1-cycle pulse)
//  fail_count     out  FAILW  saturating count of failed checks
// BEHAVIOUR
//  - cmd = {cs_n,ras_n,cas_n,we_n}:
//    - 0000 LMR, 0001 AREF, 0010 PRE, 0011 ACT, 0100 WR, 0101 RD, 0110 BST, 0111 NOP
//    - any code with cs_n=1 is treated as NOP.
//  - Legal command sets:
//    - nop  = cs_n | NOP
//    - idle = nop | ACT | AREF | LMR | PRE
//    - act  = nop | RD | WR | PRE
//    - xfr  = act | BST
//  - bank0 = (sdr_ba==2'b00).
//  - States:
//    - 0 INIT, 1 IDLE, 2 REFRESHING, 3 ACTIVATING, 4 ACTIVE, 5 RD, 6 RD_W_PC,
//      7 WR, 8 WR_W_PC, 9 PRECHARGING
//    - codes 10-15 unreachable; if entered, the next state is IDLE.
//  - Transitions, registered (cnt = dwell counter):
//    - INIT -> IDLE when sdr_init_done.
//    - IDLE -> ACTIVATING on ACT&bank0; IDLE -> REFRESHING on AREF&bank0.
//    - REFRESHING -> IDLE after 1 cycle. PRECHARGING -> IDLE after 1 cycle.
//    - ACTIVATING -> ACTIVE when cnt>=TRCD, i.e. TRCD+1 cycles of residency.
//    - ACTIVE, on bank0 commands:
//      - WR -> WR_W_PC if addr10, else WR
//      - RD -> RD_W_PC if addr10, else RD
//      - PRE -> PRECHARGING
//    - RD/WR, by priority:
//      - WR&bank0 -> WR
//      - RD&bank0 -> RD
//      - PRE&(bank0|addr10) -> PRECHARGING
//      - BST&bank0 -> ACTIVE
//      - else cnt>=BURST_LENGTH -> ACTIVE, otherwise hold.
//    - RD_W_PC/WR_W_PC -> PRECHARGING when cnt>=BURST_LENGTH.
//  - Dwell counter:
//    - 0 in INIT/IDLE/ACTIVE.
//    - +1 each cycle spent in REFRESHING, ACTIVATING, RD*, WR*, PRECHARGING.
//    - cleared whenever bank_state changes.
//    - RD->RD and WR->WR re-issue: counter is not cleared.
//  - Check (every cycle with bank0 and state!=INIT), required set by state:
//    - IDLE -> idle; ACTIVE -> act; RD/WR -> xfr
//    - REFRESHING/ACTIVATING/RD_W_PC/WR_W_PC/PRECHARGING -> nop
//  - Check outputs:
//    - chk_valid/chk_fail are registered; they report the previous cycle's check.
//    - fail_count increments on each failure and saturates at all-ones.
//  - Reset: bank_state=INIT, cnt=0, chk_valid=0, chk_fail=0, fail_count=0.
//    Reset mid-burst returns to INIT immediately.
//  - Non-bank0 commands: no transition (except PRE with addr10 in RD/WR);
//    no check performed.
// STRUCTURE
//  - sdr_mon_pkg holds:
//    - bank_state_t (logic[3:0])
//    - cmd_t (bit[3:0]) with the codes above
//    - function cmd_legal(bank_state_t, cmd_t).
//  - One natural sub-module: sdr_cmd_decode (pins -> cmd_t plus the
//    nop/idle/act/xfr flags).
// TESTING
//  - Reset, then init_done=1 -> bank_state=IDLE next cycle; chk_valid stays 0
//    while in INIT.
//  - IDLE, ACT ba=0, TRCD=1 -> ACTIVATING for 2 cycles, then ACTIVE.
//  - ACTIVE, RD ba=0 addr10=1, BL=1 -> RD_W_PC 2 cycles, PRECHARGING, IDLE.
//  - ACTIVATING + RD ba=0 -> chk_fail=1 next cycle, fail_count=1.
//  - RD state + BST ba=0 -> ACTIVE, check passes.
//  - ACTIVE + RD ba=2'b01 -> state unchanged, chk_valid=0.

Source files
------------

// File: rtl/sdr_mon_pkg.sv
// Shared types and helpers for the SDRAM bank-0 protocol monitor.
package sdr_mon_pkg;

    // Bank-0 state encoding; codes 10-15 are unused.
    typedef logic [3:0] bank_state_t;

    localparam bank_state_t ST_INIT        = 4'd0;
    localparam bank_state_t ST_IDLE        = 4'd1;
    localparam bank_state_t ST_REFRESHING  = 4'd2;
    localparam bank_state_t ST_ACTIVATING  = 4'd3;
    localparam bank_state_t ST_ACTIVE      = 4'd4;
    localparam bank_state_t ST_RD          = 4'd5;
    localparam bank_state_t ST_RD_W_PC     = 4'd6;
    localparam bank_state_t ST_WR          = 4'd7;
    localparam bank_state_t ST_WR_W_PC     = 4'd8;
    localparam bank_state_t ST_PRECHARGING = 4'd9;

    // Command code is {cs_n, ras_n, cas_n, we_n}; deselect folds into NOP.
    typedef enum bit [3:0] {
        CMD_LMR  = 4'b0000,
        CMD_AREF = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_BST  = 4'b0110,
        CMD_NOP  = 4'b0111
    } cmd_t;

    function automatic logic cmd_in_nop(input cmd_t c);
        return (c == CMD_NOP);
    endfunction

    function automatic logic cmd_in_idle(input cmd_t c);
        return cmd_in_nop(c) || (c == CMD_ACT) || (c == CMD_AREF) ||
               (c == CMD_LMR) || (c == CMD_PRE);
    endfunction

    function automatic logic cmd_in_act(input cmd_t c);
        return cmd_in_nop(c) || (c == CMD_RD) || (c == CMD_WR) || (c == CMD_PRE);
    endfunction

    function automatic logic cmd_in_xfr(input cmd_t c);
        return cmd_in_act(c) || (c == CMD_BST);
    endfunction

    // Whether a bank-0 command is allowed in the given state.
    function automatic logic cmd_legal(input bank_state_t s, input cmd_t c);
        case (s)
            ST_INIT:      return 1'b1;
            ST_IDLE:      return cmd_in_idle(c);
            ST_ACTIVE:    return cmd_in_act(c);
            ST_RD, ST_WR: return cmd_in_xfr(c);
            default:      return cmd_in_nop(c);
        endcase
    endfunction

endpackage

// File: rtl/sdr_cmd_decode.sv
// Decodes SDRAM command pins into a command code and legal-set flags.
module sdr_cmd_decode
    import sdr_mon_pkg::*;
(
    input  logic i_cs_n,
    input  logic i_ras_n,
    input  logic i_cas_n,
    input  logic i_we_n,
    output cmd_t o_cmd,
    output logic o_nop,
    output logic o_idle,
    output logic o_act,
    output logic o_xfr
);

    cmd_t w_cmd;

    // Deselected cycles look exactly like NOP to the rest of the monitor.
    always_comb begin
        w_cmd = CMD_NOP;
        if (!i_cs_n) begin
            w_cmd = cmd_t'({1'b0, i_ras_n, i_cas_n, i_we_n});
        end
    end

    assign o_cmd  = w_cmd;
    assign o_nop  = cmd_in_nop(w_cmd);
    assign o_idle = cmd_in_idle(w_cmd);
    assign o_act  = cmd_in_act(w_cmd);
    assign o_xfr  = cmd_in_xfr(w_cmd);

endmodule

// File: rtl/sdr_bank0_protocol_checker.sv
// Passive monitor tracking SDRAM bank 0 and flagging illegal bank-0 commands.
//
//   state          | meaning
//   INIT           | waiting for controller init to finish, no checking
//   IDLE           | bank closed
//   REFRESHING     | auto-refresh in progress, 1 cycle
//   ACTIVATING     | row opening, TRCD+1 cycles
//   ACTIVE         | row open
//   RD / WR        | burst in progress, may be re-issued or terminated
//   RD_W_PC/WR_W_PC| burst followed by automatic precharge
//   PRECHARGING    | row closing, 1 cycle
module sdr_bank0_protocol_checker
    import sdr_mon_pkg::*;
#(
    parameter int BURST_LENGTH = 1,
    parameter int TRCD         = 1,
    parameter int TRAS         = 1,
    parameter int TCAS         = 1,
    parameter int TRP          = 1,
    parameter int FAILW        = 16
) (
    input  logic             sdram_clk,
    input  logic             sdram_rst,
    input  logic             sdr_init_done,
    input  logic             sdr_cs_n,
    input  logic             sdr_ras_n,
    input  logic             sdr_cas_n,
    input  logic             sdr_we_n,
    input  logic [1:0]       sdr_ba,
    input  logic             sdr_addr10,
    output logic [3:0]       bank_state,
    output logic             chk_valid,
    output logic             chk_fail,
    output logic [FAILW-1:0] fail_count
);

    // The dwell counter only has to reach the largest timing value, so size
    // it from all timing parameters and let it saturate there.
    localparam int CNT_MAX_A = (BURST_LENGTH > TRCD) ? BURST_LENGTH : TRCD;
    localparam int CNT_MAX_B = (TRAS > TCAS) ? TRAS : TCAS;
    localparam int CNT_MAX_C = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_MAX   = (CNT_MAX_C > TRP) ? CNT_MAX_C : TRP;
    localparam int CNT_W     = $clog2(CNT_MAX + 2);

    localparam logic [CNT_W-1:0] TRCD_C = CNT_W'(TRCD);
    localparam logic [CNT_W-1:0] BL_C   = CNT_W'(BURST_LENGTH);

    bank_state_t      r_state;
    bank_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_chk_valid;
    logic             r_chk_fail;
    logic [FAILW-1:0] r_fail_count;

    cmd_t w_cmd;
    logic w_nop, w_idle, w_act, w_xfr;
    logic w_bank0;
    logic w_chk;
    logic w_legal;
    logic w_fail;
    logic w_counting;

    sdr_cmd_decode u_decode (
        .i_cs_n  (sdr_cs_n),
        .i_ras_n (sdr_ras_n),
        .i_cas_n (sdr_cas_n),
        .i_we_n  (sdr_we_n),
        .o_cmd   (w_cmd),
        .o_nop   (w_nop),
        .o_idle  (w_idle),
        .o_act   (w_act),
        .o_xfr   (w_xfr)
    );

    assign w_bank0 = (sdr_ba == 2'b00);

    // Next bank state from the current state, the snooped command and dwell time.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (sdr_init_done) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_bank0 && w_cmd == CMD_ACT)       w_state_nxt = ST_ACTIVATING;
                else if (w_bank0 && w_cmd == CMD_AREF) w_state_nxt = ST_REFRESHING;
            end
            ST_REFRESHING, ST_PRECHARGING: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ACTIVATING: begin
                if (r_cnt >= TRCD_C) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_bank0) begin
                    if (w_cmd == CMD_WR)      w_state_nxt = sdr_addr10 ? ST_WR_W_PC : ST_WR;
                    else if (w_cmd == CMD_RD) w_state_nxt = sdr_addr10 ? ST_RD_W_PC : ST_RD;
                    else if (w_cmd == CMD_PRE) w_state_nxt = ST_PRECHARGING;
                end
            end
            ST_RD, ST_WR: begin
                // A precharge-all on another bank still closes bank 0.
                if (w_bank0 && w_cmd == CMD_WR)                      w_state_nxt = ST_WR;
                else if (w_bank0 && w_cmd == CMD_RD)                 w_state_nxt = ST_RD;
                else if (w_cmd == CMD_PRE && (w_bank0 || sdr_addr10)) w_state_nxt = ST_PRECHARGING;
                else if (w_bank0 && w_cmd == CMD_BST)                w_state_nxt = ST_ACTIVE;
                else if (r_cnt >= BL_C)                              w_state_nxt = ST_ACTIVE;
            end
            ST_RD_W_PC, ST_WR_W_PC: begin
                if (r_cnt >= BL_C) w_state_nxt = ST_PRECHARGING;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Dwell counter runs only in timed states; a re-issued burst keeps counting.
    always_comb begin
        w_counting = 1'b0;
        case (r_state)
            ST_REFRESHING, ST_ACTIVATING, ST_RD, ST_RD_W_PC,
            ST_WR, ST_WR_W_PC, ST_PRECHARGING: w_counting = 1'b1;
            default:                           w_counting = 1'b0;
        endcase
        w_cnt_nxt = '0;
        if (w_state_nxt == r_state && w_counting) begin
            w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // Required command set for the current state.
    always_comb begin
        w_legal = 1'b1;
        case (r_state)
            ST_INIT:      w_legal = 1'b1;
            ST_IDLE:      w_legal = w_idle;
            ST_ACTIVE:    w_legal = w_act;
            ST_RD, ST_WR: w_legal = w_xfr;
            default:      w_legal = w_nop;
        endcase
    end

    assign w_chk  = w_bank0 && (r_state != ST_INIT);
    assign w_fail = w_chk && !w_legal;

    // State, dwell counter and registered check results.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_chk_valid  <= 1'b0;
            r_chk_fail   <= 1'b0;
            r_fail_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_chk_valid <= w_chk;
            r_chk_fail  <= w_fail;
            if (w_fail && !(&r_fail_count)) begin
                r_fail_count <= r_fail_count + 1'b1;
            end
        end
    end

    assign bank_state = r_state;
    assign chk_valid  = r_chk_valid;
    assign chk_fail   = r_chk_fail;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_sdr_bank0_protocol_checker.sv
// Directed bench for the bank-0 protocol monitor.
module tb_sdr_bank0_protocol_checker;

    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_BST  = 4'b0110;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DESL = 4'b1111;

    localparam logic [3:0] S_INIT = 4'd0, S_IDLE = 4'd1, S_REF = 4'd2, S_ACTG = 4'd3,
                           S_ACT = 4'd4, S_RD = 4'd5, S_RDPC = 4'd6, S_WR = 4'd7,
                           S_PRE = 4'd9;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       cs_n, ras_n, cas_n, we_n;
    logic [1:0] ba;
    logic       a10;
    logic [3:0] bank_state;
    logic       chk_valid;
    logic       chk_fail;
    logic [1:0] fail_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdr_bank0_protocol_checker #(
        .BURST_LENGTH (1),
        .TRCD         (1),
        .TRAS         (1),
        .TCAS         (1),
        .TRP          (1),
        .FAILW        (2)
    ) dut (
        .sdram_clk     (clk),
        .sdram_rst     (rst),
        .sdr_init_done (init_done),
        .sdr_cs_n      (cs_n),
        .sdr_ras_n     (ras_n),
        .sdr_cas_n     (cas_n),
        .sdr_we_n      (we_n),
        .sdr_ba        (ba),
        .sdr_addr10    (a10),
        .bank_state    (bank_state),
        .chk_valid     (chk_valid),
        .chk_fail      (chk_fail),
        .fail_count    (fail_count)
    );

    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic a);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba  = b;
        a10 = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] st, input logic v,
                           input logic f, input logic [1:0] fc);
        chk({tag, ".state"}, 16'(bank_state), 16'(st));
        chk({tag, ".valid"}, 16'(chk_valid), 16'(v));
        chk({tag, ".fail"},  16'(chk_fail),  16'(f));
        chk({tag, ".count"}, 16'(fail_count), 16'(fc));
    endtask

    initial begin
        rst = 1'b1;
        init_done = 1'b0;
        drive(C_DESL, 2'b00, 1'b0);
        step();
        step();
        chk_all("reset", S_INIT, 1'b0, 1'b0, 2'd0);

        rst = 1'b0;
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("init_hold", S_INIT, 1'b0, 1'b0, 2'd0);

        init_done = 1'b1;
        step();
        chk_all("init_done", S_IDLE, 1'b0, 1'b0, 2'd0);

        drive(C_ACT, 2'b00, 1'b0);
        step();
        chk_all("act", S_ACTG, 1'b1, 1'b0, 2'd0);
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("actg2", S_ACTG, 1'b1, 1'b0, 2'd0);
        step();
        chk_all("active", S_ACT, 1'b1, 1'b0, 2'd0);

        drive(C_RD, 2'b01, 1'b0);
        step();
        chk_all("rd_bank1", S_ACT, 1'b0, 1'b0, 2'd0);

        drive(C_RD, 2'b00, 1'b1);
        step();
        chk_all("rdpc", S_RDPC, 1'b1, 1'b0, 2'd0);
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("rdpc2", S_RDPC, 1'b1, 1'b0, 2'd0);
        step();
        chk_all("rdpc_pre", S_PRE, 1'b1, 1'b0, 2'd0);
        step();
        chk_all("rdpc_idle", S_IDLE, 1'b1, 1'b0, 2'd0);

        drive(C_ACT, 2'b00, 1'b0);
        step();
        chk_all("act2", S_ACTG, 1'b1, 1'b0, 2'd0);
        drive(C_RD, 2'b00, 1'b0);
        step();
        chk_all("rd_in_actg", S_ACTG, 1'b1, 1'b1, 2'd1);
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("active2", S_ACT, 1'b1, 1'b0, 2'd1);

        drive(C_RD, 2'b00, 1'b0);
        step();
        chk_all("rd", S_RD, 1'b1, 1'b0, 2'd1);
        drive(C_BST, 2'b00, 1'b0);
        step();
        chk_all("bst_in_rd", S_ACT, 1'b1, 1'b0, 2'd1);

        drive(C_BST, 2'b00, 1'b0);
        step();
        chk_all("bst_in_active", S_ACT, 1'b1, 1'b1, 2'd2);

        drive(C_WR, 2'b00, 1'b0);
        step();
        chk_all("wr", S_WR, 1'b1, 1'b0, 2'd2);
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("wr_hold", S_WR, 1'b1, 1'b0, 2'd2);
        step();
        chk_all("wr_done", S_ACT, 1'b1, 1'b0, 2'd2);

        drive(C_RD, 2'b00, 1'b0);
        step();
        chk_all("rd_a", S_RD, 1'b1, 1'b0, 2'd2);
        step();
        chk_all("rd_reissue", S_RD, 1'b1, 1'b0, 2'd2);
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("rd_reissue_end", S_ACT, 1'b1, 1'b0, 2'd2);

        drive(C_WR, 2'b00, 1'b0);
        step();
        chk_all("wr2", S_WR, 1'b1, 1'b0, 2'd2);
        drive(C_PRE, 2'b10, 1'b1);
        step();
        chk_all("pre_all_other", S_PRE, 1'b0, 1'b0, 2'd2);
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("pre_idle", S_IDLE, 1'b1, 1'b0, 2'd2);

        drive(C_AREF, 2'b00, 1'b0);
        step();
        chk_all("aref", S_REF, 1'b1, 1'b0, 2'd2);
        drive(C_LMR, 2'b00, 1'b0);
        step();
        chk_all("lmr_in_ref", S_IDLE, 1'b1, 1'b1, 2'd3);

        drive(C_ACT, 2'b00, 1'b0);
        step();
        drive(C_NOP, 2'b00, 1'b0);
        step();
        step();
        drive(C_RD, 2'b00, 1'b0);
        step();
        chk_all("rd_pre_reset", S_RD, 1'b1, 1'b0, 2'd3);
        rst = 1'b1;
        step();
        chk_all("mid_reset", S_INIT, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        drive(C_NOP, 2'b00, 1'b0);
        step();
        chk_all("reinit", S_IDLE, 1'b0, 1'b0, 2'd0);

        drive(C_RD, 2'b00, 1'b0);
        step();
        chk_all("sat1", S_IDLE, 1'b1, 1'b1, 2'd1);
        step();
        chk_all("sat2", S_IDLE, 1'b1, 1'b1, 2'd2);
        step();
        chk_all("sat3", S_IDLE, 1'b1, 1'b1, 2'd3);
        step();
        chk_all("sat4", S_IDLE, 1'b1, 1'b1, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
